lbm_sweep_controller: RTL and testbench



---
 rtl/lbm_ctrl_pkg.sv | 24 ++
 rtl/lbm_cell_classifier.sv | 36 +++
 rtl/lbm_sweep_controller.sv | 169 ++++++++++++++++
 tb/tb_lbm_sweep_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lbm_ctrl_pkg.sv
// Shared types and default lattice size for the LBM sweep controller.
package lbm_ctrl_pkg;

  // Phase code presented to the datapath alongside each cell.
  typedef enum logic [1:0] {
    PH_IDLE     = 2'b00,
    PH_COLLIDE  = 2'b01,
    PH_STREAM   = 2'b10,
    PH_BOUNDARY = 2'b11
  } phase_t;

  // Controller FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLIDE,
    S_STREAM,
    S_BOUNDARY,
    S_DONE
  } state_t;

  localparam int DEF_GRID_X = 16;
  localparam int DEF_GRID_Y = 16;

endpackage : lbm_ctrl_pkg

// File: rtl/lbm_cell_classifier.sv
// Maps a cell coordinate to its cavity wall class.
// The four flags are one-hot or all zero.
// Priority is lid > bottom > left > right, so corners get exactly one class.
module lbm_cell_classifier #(
  parameter int GRID_X = 16,
  parameter int GRID_Y = 16,
  parameter int X_W    = $clog2(GRID_X),
  parameter int Y_W    = $clog2(GRID_Y)
) (
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  output logic           lid_o,
  output logic           bottom_o,
  output logic           left_o,
  output logic           right_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_X - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_Y - 1);

  logic is_lid, is_bottom, is_left, is_right;

  assign is_lid    = (x_i == X_MAX) && (y_i != '0) && (y_i != Y_MAX);
  assign is_bottom = (x_i == '0);
  assign is_left   = (y_i == '0);
  assign is_right  = (y_i == Y_MAX);

  // Resolve overlapping edges so that each cell carries at most one class.
  always_comb begin
    lid_o    = is_lid;
    bottom_o = !is_lid && is_bottom;
    left_o   = !is_lid && !is_bottom && is_left;
    right_o  = !is_lid && !is_bottom && !is_left && is_right;
  end

endmodule : lbm_cell_classifier

// File: rtl/lbm_sweep_controller.sv
// Lattice sweep sequencer that runs one LBM timestep at a time.
// Each timestep has three phases: COLLIDE, STREAM and BOUNDARY.
// Each cell is offered to the datapath over a valid/ready handshake.
module lbm_sweep_controller
  import lbm_ctrl_pkg::*;
#(
  parameter int GRID_X = DEF_GRID_X,
  parameter int GRID_Y = DEF_GRID_Y,
  parameter int X_W    = $clog2(GRID_X),
  parameter int Y_W    = $clog2(GRID_Y),
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              cell_ready,
  output logic              cell_valid,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [1:0]        phase,
  output logic              lid,
  output logic              bottom_wall,
  output logic              left_wall,
  output logic              right_wall,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              done
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_X - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_Y - 1);

  state_t            state_q;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] count_q, count_d;
  logic              busy_q, done_q;
  logic              grid_end;
  logic              c_lid, c_bottom, c_left, c_right, wall_any;
  logic              active, advance;
  phase_t            phase_enc;

  lbm_cell_classifier #(
    .GRID_X (GRID_X),
    .GRID_Y (GRID_Y),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_classifier (
    .x_i      (x_q),
    .y_i      (y_q),
    .lid_o    (c_lid),
    .bottom_o (c_bottom),
    .left_o   (c_left),
    .right_o  (c_right)
  );

  assign wall_any = c_lid | c_bottom | c_left | c_right;
  assign active   = (state_q == S_COLLIDE) || (state_q == S_STREAM) || (state_q == S_BOUNDARY);
  assign count_d  = count_q + STEP_W'(1);

  // Next raster coordinate: x is the fast index, and the grid end is flagged on the final cell.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    grid_end = 1'b0;
    if (x_q == X_MAX) begin
      x_d = '0;
      if (y_q == Y_MAX) begin
        y_d      = '0;
        grid_end = 1'b1;
      end else begin
        y_d = y_q + Y_W'(1);
      end
    end else begin
      x_d = x_q + X_W'(1);
    end
  end

  // Present cells in the compute phases, and only wall cells in BOUNDARY.
  // Non-wall BOUNDARY cells are skipped after one cycle without a handshake.
  always_comb begin
    cell_valid = (state_q == S_COLLIDE) || (state_q == S_STREAM) ||
                 ((state_q == S_BOUNDARY) && wall_any);
    advance    = (cell_valid && cell_ready) || ((state_q == S_BOUNDARY) && !wall_any);
  end

  // Decode the externally visible phase from the state register.
  always_comb begin
    unique case (state_q)
      S_COLLIDE:  phase_enc = PH_COLLIDE;
      S_STREAM:   phase_enc = PH_STREAM;
      S_BOUNDARY: phase_enc = PH_BOUNDARY;
      default:    phase_enc = PH_IDLE;
    endcase
  end

  // Sweep FSM, including the coordinate, timestep and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      steps_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            steps_q <= num_steps;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            if (num_steps == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_COLLIDE;
            end
          end
        end
        S_COLLIDE, S_STREAM: begin
          if (advance) begin
            x_q <= x_d;
            y_q <= y_d;
            if (grid_end) state_q <= (state_q == S_COLLIDE) ? S_STREAM : S_BOUNDARY;
          end
        end
        S_BOUNDARY: begin
          if (advance) begin
            x_q <= x_d;
            y_q <= y_d;
            if (grid_end) begin
              count_q <= count_d;
              if (count_d == steps_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_COLLIDE;
              end
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign phase       = phase_enc;
  assign lid         = active & c_lid;
  assign bottom_wall = active & c_bottom;
  assign left_wall   = active & c_left;
  assign right_wall  = active & c_right;
  assign step_count  = count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule : lbm_sweep_controller

// File: tb/tb_lbm_sweep_controller.sv
// Directed and randomized checks of the sweep controller against a queue-based reference.
module tb_lbm_sweep_controller;

  localparam int GX = 16;
  localparam int GY = 16;
  localparam int CELLS_PER_STEP = 2 * GX * GY + 60;
  localparam int CYC_PER_STEP   = 3 * GX * GY;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_steps;
  logic        cell_ready;
  logic        cell_valid;
  logic [3:0]  x, y;
  logic [1:0]  phase;
  logic        lid, bottom_wall, left_wall, right_wall;
  logic [15:0] step_count;
  logic        busy, done;

  logic [3:0]  cx, cy;
  logic        c_lid, c_bottom, c_left, c_right;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lbm_sweep_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_steps   (num_steps),
    .cell_ready  (cell_ready),
    .cell_valid  (cell_valid),
    .x           (x),
    .y           (y),
    .phase       (phase),
    .lid         (lid),
    .bottom_wall (bottom_wall),
    .left_wall   (left_wall),
    .right_wall  (right_wall),
    .step_count  (step_count),
    .busy        (busy),
    .done        (done)
  );

  lbm_cell_classifier #(.GRID_X(GX), .GRID_Y(GY)) u_ref_cls (
    .x_i      (cx),
    .y_i      (cy),
    .lid_o    (c_lid),
    .bottom_o (c_bottom),
    .left_o   (c_left),
    .right_o  (c_right)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wall class {lid,bottom,left,right} of a cell, with lid taking precedence over the other edges.
  function automatic logic [3:0] wall_fn(input int xx, input int yy);
    if (xx == GX - 1 && yy >= 1 && yy <= GY - 2) return 4'b1000;
    if (xx == 0)                                 return 4'b0100;
    if (yy == 0)                                 return 4'b0010;
    if (yy == GY - 1)                            return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic logic [13:0] pk(input logic [1:0] p, input logic [3:0] xx,
                                     input logic [3:0] yy, input logic [3:0] f);
    return {p, xx, yy, f};
  endfunction

  // One run: start, then check every cycle until done, matching handshakes against the expected cell list.
  task automatic run(input int n, input int ready_pct, input bit exact,
                     input bit repulse, input bit abort57);
    logic [13:0] q[$];
    logic [13:0] cur, prev, head;
    logic [3:0]  f;
    int cyc, hs, bcyc, bval, wl, wb, wlf, wr, last_sc;
    bit pv, pr, finished;
    for (int s = 0; s < n; s++)
      for (int ph = 1; ph <= 3; ph++)
        for (int yy = 0; yy < GY; yy++)
          for (int xx = 0; xx < GX; xx++) begin
            f = wall_fn(xx, yy);
            if (ph != 3 || f != 4'b0) q.push_back(pk(2'(ph), 4'(xx), 4'(yy), f));
          end
    hs = 0; bcyc = 0; bval = 0; wl = 0; wb = 0; wlf = 0; wr = 0;
    last_sc = 0; pv = 0; pr = 0; prev = '0; finished = 0;
    num_steps  = 16'(n);
    start      = 1'b1;
    cell_ready = ($urandom_range(99) < ready_pct);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 20000) begin
      cur = pk(phase, x, y, {lid, bottom_wall, left_wall, right_wall});
      if (cyc == 1) begin
        chk("start_clears_step_count", step_count, 0);
        if (n > 0) begin
          chk("first_valid", cell_valid, 1);
          chk("first_cell", cur, pk(2'b01, 4'd0, 4'd0, wall_fn(0, 0)));
        end
      end
      if (abort57 && phase == 2'b10 && x == 4'd5 && y == 4'd7) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {cell_valid, x, y, phase, lid, bottom_wall, left_wall, right_wall, step_count, busy, done},
            '0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (repulse && cyc == 100);
      if (repulse && cyc == 100) num_steps = 16'd7;
      if (phase != 2'b00) chk("flags", cur[3:0], wall_fn(x, y));
      else                chk("flags_idle", cur[3:0], 0);
      chk("valid_rule", cell_valid,
          (phase == 2'b01 || phase == 2'b10) ? 1 : (phase == 2'b11) ? (wall_fn(x, y) != 4'b0) : 0);
      chk("busy_during_run", busy, 1);
      if (pv && !pr) chk("stall_hold", cur, prev);
      if (int'(step_count) != last_sc) begin
        chk("step_inc", step_count, last_sc + 1);
        chk("step_hs", hs, int'(step_count) * CELLS_PER_STEP);
        last_sc = int'(step_count);
      end
      if (phase == 2'b11) begin
        bcyc++;
        if (cell_valid) bval++;
      end
      if (done) begin
        finished = 1;
        if (exact) chk("done_cycle", cyc, n * CYC_PER_STEP + 1);
        chk("done_step_count", step_count, n);
        chk("done_handshakes", hs, n * CELLS_PER_STEP);
        chk("done_queue_empty", q.size(), 0);
        chk("done_quiet", {cell_valid, phase}, 0);
      end else begin
        cell_ready = ($urandom_range(99) < ready_pct);
        if (cell_valid && cell_ready) begin
          hs++;
          if (q.size() == 0) chk("extra_handshake", 1, 0);
          else begin
            head = q.pop_front();
            chk("handshake_cell", cur, head);
          end
          if (phase == 2'b11) begin
            wl += int'(lid); wb += int'(bottom_wall); wlf += int'(left_wall); wr += int'(right_wall);
          end
        end
        pv = cell_valid;
        pr = cell_ready;
        prev = cur;
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) begin
      chk("timeout_no_done", 0, 1);
      return;
    end
    if (exact) begin
      chk("boundary_cycles", bcyc, n * GX * GY);
      chk("boundary_valid_cycles", bval, n * 60);
    end
    chk("lid_count", wl, n * 14);
    chk("bottom_count", wb, n * 16);
    chk("left_count", wlf, n * 15);
    chk("right_count", wr, n * 15);
    @(negedge clk);
    chk("after_done_idle", {done, busy, cell_valid, phase}, 0);
    chk("step_count_holds", step_count, n);
    $display("run n=%0d ready=%0d%% cycles=%0d handshakes=%0d", n, ready_pct, cyc, hs);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cell_ready = 1'b0; num_steps = '0; cx = '0; cy = '0;
    // Reference classifier sweep plus a few named corners.
    for (int yy = 0; yy < GY; yy++)
      for (int xx = 0; xx < GX; xx++) begin
        cx = 4'(xx); cy = 4'(yy);
        #1;
        chk("classifier_cell", {c_lid, c_bottom, c_left, c_right}, wall_fn(xx, yy));
      end
    cx = 4'd15; cy = 4'd15; #1; chk("cell_15_15_right", {c_lid, c_bottom, c_left, c_right}, 4'b0001);
    cx = 4'd0;  cy = 4'd15; #1; chk("cell_0_15_bottom", {c_lid, c_bottom, c_left, c_right}, 4'b0100);
    cx = 4'd15; cy = 4'd0;  #1; chk("cell_15_0_left",   {c_lid, c_bottom, c_left, c_right}, 4'b0010);
    cx = 4'd15; cy = 4'd1;  #1; chk("cell_15_1_lid",    {c_lid, c_bottom, c_left, c_right}, 4'b1000);
    repeat (3) @(negedge clk);
    chk("reset_state",
        {cell_valid, x, y, phase, lid, bottom_wall, left_wall, right_wall, step_count, busy, done}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, cell_valid, phase}, 0);

    run(1, 100, 1'b1, 1'b0, 1'b0);
    run(3, 50, 1'b0, 1'b0, 1'b0);
    run(0, 100, 1'b1, 1'b0, 1'b0);
    run(1, 100, 1'b1, 1'b1, 1'b0);
    run(2, 70, 1'b0, 1'b0, 1'b0);
    run(1, 100, 1'b0, 1'b0, 1'b1);
    chk("idle_after_abort", {busy, done, cell_valid, phase, step_count}, 0);
    run(1, 60, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lbm_sweep_controller
